// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the time-shared ALU controller: ALU op codes,
// condition-code bit positions, controller states and arbitration helpers.
package alu_share_ctrl_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester that did not win last time.
    function automatic logic pick_grant(input logic [1:0] valid, input logic last_grant);
        logic idx;
        case (valid)
            2'b01:   idx = 1'b0;
            2'b10:   idx = 1'b1;
            2'b11:   idx = ~last_grant;
            default: idx = 1'b0;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Combinational ALU shared by both issue slots: add, sub, and, xor with
// zero/sign/overflow flags.
module alu
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 64
)(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       cf
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    // Signed overflow: result sign disagrees with what the operand signs allow.
    assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
    assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        out = '0;
        cf  = '0;
        case (control)
            ALU_ADD: begin
                out       = w_sum;
                cf[CC_OF] = w_add_ovf;
            end
            ALU_SUB: begin
                out       = w_diff;
                cf[CC_OF] = w_sub_ovf;
            end
            ALU_AND: out = a & b;
            ALU_XOR: out = a ^ b;
            default: out = '0;
        endcase
        cf[CC_ZF] = (out == '0);
        cf[CC_SF] = out[WIDTH-1];
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin time-sharing of one ALU between two execute-stage issue slots,
// with registered operands/results and the architectural condition codes.
//
// state   | meaning
// IDLE    | no op in flight; arbitrate and accept one request
// BUSY    | ALU evaluates latched operands; result captured at the edge
// RESP    | result held for the owner until it is consumed
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = 3'b001
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    input  logic             req_cc0,
    input  logic             req_cc1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic [2:0]       rsp_cf,
    output logic [2:0]       cc
);

    state_t           r_state;
    logic             r_last_grant;
    logic             r_owner;
    logic             r_cc_en;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [1:0]       r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_out;
    logic [2:0]       r_rsp_cf;
    logic [2:0]       r_cc;

    logic             w_any_valid;
    logic             w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu_out;
    logic [2:0]       w_alu_cf;

    assign w_any_valid = |req_valid;
    assign w_grant     = pick_grant(req_valid, r_last_grant);
    assign w_accept    = (r_state == ST_IDLE) && !flush && w_any_valid;
    assign req_ready   = w_accept ? grant_onehot(w_grant) : 2'b00;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a       (r_a),
        .b       (r_b),
        .control (r_op),
        .out     (w_alu_out),
        .cf      (w_alu_cf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cc_en      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= ALU_ADD;
            r_rsp_valid  <= 2'b00;
            r_rsp_out    <= '0;
            r_rsp_cf     <= 3'b000;
            r_cc         <= CC_RESET;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_grant ? req_a1  : req_a0;
                        r_b          <= w_grant ? req_b1  : req_b0;
                        r_op         <= w_grant ? req_op1 : req_op0;
                        r_cc_en      <= w_grant ? req_cc1 : req_cc0;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A flush here drops the op before it can touch cc.
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rsp_out   <= w_alu_out;
                        r_rsp_cf    <= w_alu_cf;
                        r_rsp_valid <= grant_onehot(r_owner);
                        if (r_cc_en) begin
                            r_cc <= w_alu_cf;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (flush || rsp_ready[r_owner]) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_out   = r_rsp_out;
    assign rsp_cf    = r_rsp_cf;
    assign cc        = r_cc;

endmodule
